// File: rtl/mem_access_stage_if.sv
// RAM-side bus of the memory-access stage: one byte per cycle, synchronous read.
//   master (stage): drives ram_addr / ram_wr / ram_dout, receives ram_din
//   slave  (RAM)  : receives address/strobe/write byte, returns ram_din one cycle later
interface mem_access_stage_if;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  modport master (output ram_addr, output ram_wr, output ram_dout, input ram_din);
  modport slave  (input ram_addr, input ram_wr, input ram_dout, output ram_din);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte-serial loads/stores over a byte-wide synchronous RAM.
//   clk, rst         : clock, synchronous active-high reset (forces all outputs to 0)
//   mem_*            : EX/MEM register outputs, held stable by the stall during an access
//   ram              : RAM bus (address, write strobe, write byte, read byte)
//   wb_*             : write-back triple to MEM/WB
//   stallreq_mem     : freezes EX/MEM and earlier stages while an access is in flight
// Non-memory ops pass straight through combinationally.
module mem_access_stage (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                mem_wd,
  input  logic                      mem_wreg,
  input  logic [31:0]               mem_wdata,
  input  logic [6:0]                mem_op,
  input  logic [2:0]                mem_funct3,
  input  logic [31:0]               mem_mem_addr,
  input  logic [31:0]               mem_reg,
  mem_access_stage_if.master        ram,
  output logic [4:0]                wb_wd,
  output logic                      wb_wreg,
  output logic [31:0]               wb_wdata,
  output logic                      stallreq_mem
);

  localparam int unsigned CNT_W    = 3;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      ld_buf_q, ld_buf_d;

  logic [CNT_W-1:0] size_c;
  logic             sgn_c, ld_ok_c, st_ok_c, is_ld_c, is_st_c;
  logic [1:0]       byte_idx_c;
  logic [31:0]      ld_ext_c;
  logic [31:0]      ram_addr_c;
  logic             ram_wr_c;
  logic [7:0]       ram_dout_c;

  // Access size / signedness from funct3; size 0 marks an unsupported encoding.
  always_comb begin
    size_c  = '0;
    sgn_c   = 1'b0;
    st_ok_c = 1'b0;
    case (mem_funct3)
      3'b000:  begin size_c = 3'd1; sgn_c = 1'b1; st_ok_c = 1'b1; end
      3'b001:  begin size_c = 3'd2; sgn_c = 1'b1; st_ok_c = 1'b1; end
      3'b010:  begin size_c = 3'd4; st_ok_c = 1'b1; end
      3'b100:  begin size_c = 3'd1; end
      3'b101:  begin size_c = 3'd2; end
      default: begin size_c = '0; end
    endcase
    ld_ok_c = (size_c != '0);
    is_ld_c = (mem_op == OP_LOAD);
    is_st_c = (mem_op == OP_STORE);
  end

  // Sign/zero extension of the assembled load word.
  always_comb begin
    ld_ext_c = ld_buf_q;
    if (n_q == 3'd1) begin
      ld_ext_c = sgn_q ? {{24{ld_buf_q[7]}}, ld_buf_q[7:0]} : {24'd0, ld_buf_q[7:0]};
    end else if (n_q == 3'd2) begin
      ld_ext_c = sgn_q ? {{16{ld_buf_q[15]}}, ld_buf_q[15:0]} : {16'd0, ld_buf_q[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      sgn_q    <= 1'b0;
      ld_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      sgn_q    <= sgn_d;
      ld_buf_q <= ld_buf_d;
    end
  end

  // Next state and all outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    sgn_d        = sgn_q;
    ld_buf_d     = ld_buf_q;
    ram_addr_c   = '0;
    ram_wr_c     = 1'b0;
    ram_dout_c   = '0;
    stallreq_mem = 1'b0;
    wb_wd        = '0;
    wb_wreg      = 1'b0;
    wb_wdata     = '0;
    // cnt is 1..N in LOAD; byte k-1 arrives in cycle k (N=4 wraps to index 3)
    byte_idx_c   = 2'(cnt_q - 3'd1);

    case (state_q)
      IDLE: begin
        if (is_ld_c && ld_ok_c) begin
          stallreq_mem = 1'b1;
          ram_addr_c   = mem_mem_addr;
          n_d          = size_c;
          sgn_d        = sgn_c;
          cnt_d        = 3'd1;
          ld_buf_d     = '0;
          state_d      = LOAD;
        end else if (is_st_c && st_ok_c) begin
          stallreq_mem = 1'b1;
          ram_wr_c     = 1'b1;
          ram_addr_c   = mem_mem_addr;
          ram_dout_c   = mem_reg[7:0];
          n_d          = size_c;
          cnt_d        = (size_c > 3'd1) ? 3'd1 : 3'd0;
          state_d      = (size_c > 3'd1) ? STORE : DONE;
        end else begin
          // Unsupported load/store encodings complete here without a register write.
          wb_wd    = mem_wd;
          wb_wreg  = (is_ld_c || is_st_c) ? 1'b0 : mem_wreg;
          wb_wdata = mem_wdata;
        end
      end
      LOAD: begin
        stallreq_mem = 1'b1;
        if (cnt_q < n_q) ram_addr_c = mem_mem_addr + 32'(cnt_q);
        ld_buf_d[{byte_idx_c, 3'b000} +: 8] = ram.ram_din;
        if (cnt_q == n_q) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      STORE: begin
        stallreq_mem = 1'b1;
        ram_wr_c     = 1'b1;
        ram_addr_c   = mem_mem_addr + 32'(cnt_q);
        ram_dout_c   = 8'(mem_reg >> {cnt_q[1:0], 3'b000});
        if (cnt_q == n_q - 3'd1) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_ld_c) begin
          wb_wd    = mem_wd;
          wb_wreg  = mem_wreg;
          wb_wdata = ld_ext_c;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset silences every output in the same cycle, aborting any access.
    if (rst) begin
      ram_addr_c   = '0;
      ram_wr_c     = 1'b0;
      ram_dout_c   = '0;
      stallreq_mem = 1'b0;
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
    end
  end

  assign ram.ram_addr = ram_addr_c;
  assign ram.ram_wr   = ram_wr_c;
  assign ram.ram_dout = ram_dout_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a byte-addressed RAM model, a transaction-level
// reference that expands each instruction into its expected per-cycle outputs,
// and one negedge compare process.
module tb_mem_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_NOP   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [6:0]  mem_op;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq_mem;

  always #5 clk = ~clk;

  mem_access_stage_if ram_if ();

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_op       (mem_op),
    .mem_funct3   (mem_funct3),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg      (mem_reg),
    .ram          (ram_if),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .stallreq_mem (stallreq_mem)
  );

  // ---------------- memories: DUT-facing RAM and reference shadow ----------------
  logic [7:0] ram_m [bit [31:0]];
  logic [7:0] sh_m  [bit [31:0]];
  logic [7:0] rd_byte;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_m.exists(a)) return ram_m[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    if (sh_m.exists(a)) return sh_m[a];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    rd_byte = ram_rd(ram_if.ram_addr);
    if (ram_if.ram_wr === 1'b1) ram_m[ram_if.ram_addr] = ram_if.ram_dout;
    ram_if.ram_din <= rd_byte;
  end

  // ---------------- expectations ----------------
  typedef struct {
    bit          stall;
    bit          wr;
    bit          chk_addr;
    logic [31:0] addr;
    bit          chk_dout;
    logic [7:0]  dout;
    bit          chk_wb;
    bit          wreg;
    bit          chk_data;
    logic [4:0]  wd;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t e_blank();
    exp_t e;
    e.stall = 1'b0; e.wr = 1'b0; e.chk_addr = 1'b0; e.addr = '0;
    e.chk_dout = 1'b0; e.dout = '0; e.chk_wb = 1'b0; e.wreg = 1'b0;
    e.chk_data = 1'b0; e.wd = '0; e.wdata = '0;
    return e;
  endfunction

  function automatic exp_t e_zero();
    exp_t e = e_blank();
    e.chk_addr = 1'b1; e.chk_dout = 1'b1; e.chk_wb = 1'b1; e.chk_data = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_busy(input bit chk_addr, input logic [31:0] addr);
    exp_t e = e_blank();
    e.stall = 1'b1; e.chk_addr = chk_addr; e.addr = addr;
    return e;
  endfunction

  function automatic exp_t e_wrb(input logic [31:0] addr, input logic [7:0] dout);
    exp_t e = e_blank();
    e.stall = 1'b1; e.wr = 1'b1; e.chk_addr = 1'b1; e.addr = addr;
    e.chk_dout = 1'b1; e.dout = dout;
    return e;
  endfunction

  function automatic exp_t e_wb(input bit wreg, input bit chk_data, input logic [4:0] wd,
                                input logic [31:0] wdata, input bit chk_addr);
    exp_t e = e_blank();
    e.chk_wb = 1'b1; e.wreg = wreg; e.chk_data = chk_data; e.wd = wd; e.wdata = wdata;
    e.chk_addr = chk_addr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: one expected record per cycle while any are queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stallreq_mem", 32'(stallreq_mem), 32'(cur.stall));
      chk("ram_wr", 32'(ram_if.ram_wr), 32'(cur.wr));
      if (cur.chk_addr) chk("ram_addr", ram_if.ram_addr, cur.addr);
      if (cur.chk_dout) chk("ram_dout", 32'(ram_if.ram_dout), 32'(cur.dout));
      if (cur.chk_wb)   chk("wb_wreg", 32'(wb_wreg), 32'(cur.wreg));
      if (cur.chk_data) begin
        chk("wb_wd", 32'(wb_wd), 32'(cur.wd));
        chk("wb_wdata", wb_wdata, cur.wdata);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(sh_rd(a + 32'(i))) << (8 * i));
    if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Apply one EX/MEM instruction, queue its expected cycles, hold it until done.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input bit use_pin, input logic [31:0] pin);
    int          n;
    int          len;
    bit          sgn;
    logic [31:0] v;
    logic [7:0]  b;
    mem_op = op; mem_funct3 = f3; mem_mem_addr = a; mem_reg = d;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    n   = size_of(f3);
    sgn = (f3 == 3'b000 || f3 == 3'b001);
    if (op == OP_LOAD && n != 0) begin
      v = load_val(a, n, sgn);
      if (use_pin) chk("load_value", v, pin);
      for (int k = 0; k < n; k++) exp_q.push_back(e_busy(1'b1, a + 32'(k)));
      exp_q.push_back(e_busy(1'b0, 32'd0));
      exp_q.push_back(e_wb(wreg, 1'b1, wd, v, 1'b0));
      len = n + 2;
    end else if (op == OP_STORE && f3 <= 3'b010) begin
      for (int k = 0; k < n; k++) begin
        b = 8'(d >> (8 * k));
        exp_q.push_back(e_wrb(a + 32'(k), b));
        sh_m[a + 32'(k)] = b;
      end
      exp_q.push_back(e_wb(1'b0, 1'b0, 5'd0, 32'd0, 1'b0));
      len = n + 1;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      exp_q.push_back(e_wb(1'b0, 1'b0, 5'd0, 32'd0, 1'b0));
      len = 1;
    end else begin
      exp_q.push_back(e_wb(wreg, 1'b1, wd, wdata, 1'b1));
      len = 1;
    end
    repeat (len) begin @(posedge clk); #1; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0]  op;
    logic [31:0] a;
    rst = 1'b1;
    mem_op = OP_ALU; mem_funct3 = 3'b000; mem_wd = 5'd7; mem_wreg = 1'b1;
    mem_wdata = 32'hA5A5_0001; mem_mem_addr = 32'h44; mem_reg = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e_zero());
      @(posedge clk); #1;
    end
    rst = 1'b0;

    issue(OP_ALU, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 1'b0, 32'h0);
    issue(OP_STORE, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sw_byte0", 32'(ram_rd(32'h100)), 32'hEF);
    chk("sw_byte1", 32'(ram_rd(32'h101)), 32'hBE);
    chk("sw_byte2", 32'(ram_rd(32'h102)), 32'hAD);
    chk("sw_byte3", 32'(ram_rd(32'h103)), 32'hDE);

    issue(OP_STORE, 3'b000, 32'h200, 32'h80, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b000, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0, 1'b1, 32'hFFFF_FF80);
    issue(OP_LOAD, 3'b100, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0, 1'b1, 32'h0000_0080);

    issue(OP_STORE, 3'b000, 32'h1FE, 32'h11, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(OP_STORE, 3'b000, 32'h1FF, 32'h22, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(OP_STORE, 3'b000, 32'h200, 32'h33, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(OP_STORE, 3'b000, 32'h201, 32'h44, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b010, 32'h1FE, 32'h0, 5'd10, 1'b1, 32'h0, 1'b1, 32'h4433_2211);

    issue(OP_STORE, 3'b001, 32'hFFFF_FFFF, 32'h0000_AB12, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sh_wrap_lo", 32'(ram_rd(32'hFFFF_FFFF)), 32'h12);
    chk("sh_wrap_hi", 32'(ram_rd(32'h0000_0000)), 32'hAB);
    issue(OP_LOAD, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd11, 1'b1, 32'h0, 1'b1, 32'hFFFF_AB12);
    issue(OP_LOAD, 3'b101, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b1, 32'h0, 1'b1, 32'h0000_AB12);

    issue(OP_LOAD, 3'b011, 32'h10, 32'h0, 5'd13, 1'b1, 32'h77, 1'b0, 32'h0);
    issue(OP_LOAD, 3'b111, 32'h10, 32'h0, 5'd13, 1'b1, 32'h77, 1'b0, 32'h0);
    issue(OP_STORE, 3'b100, 32'h10, 32'h55, 5'd13, 1'b1, 32'h77, 1'b0, 32'h0);

    // Reset lands in cycle 2 of an SW: only the first two bytes may be written.
    mem_op = OP_STORE; mem_funct3 = 3'b010; mem_mem_addr = 32'h300;
    mem_reg = 32'hCAFE_F00D; mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h0;
    exp_q.push_back(e_wrb(32'h300, 8'h0D)); sh_m[32'h300] = 8'h0D;
    @(posedge clk); #1;
    exp_q.push_back(e_wrb(32'h301, 8'hF0)); sh_m[32'h301] = 8'hF0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(e_zero());
    @(posedge clk); #1;
    rst = 1'b0;
    issue(OP_NOP, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 32'h600D, 1'b0, 32'h0);
    chk("rst_no_byte2", 32'(ram_rd(32'h302)), 32'h5B);
    chk("rst_no_byte3", 32'(ram_rd(32'h303)), 32'h5A);
    issue(OP_LOAD, 3'b010, 32'h300, 32'h0, 5'd14, 1'b1, 32'h0, 1'b1, 32'h5A5B_F00D);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        2:       op = OP_ALU;
        default: op = OP_NOP;
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      issue(op, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom), 1'($urandom),
            $urandom, 1'b0, 32'h0);
    end

    repeat (2) @(posedge clk);
    foreach (ram_m[k]) chk("ram_contents", 32'(ram_m[k]), 32'(sh_rd(k)));
    foreach (sh_m[k])  chk("ram_written", 32'(ram_rd(k)), 32'(sh_m[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RISC-V pipeline. It consumes the registered EX/MEM outputs (destination, write-back data, opcode, funct3, effective address, store data) and performs loads and stores over a byte-wide synchronous data RAM. While an access is in progress it holds a stall request to the pipeline controller, which freezes EX/MEM and earlier stages. It then presents the write-back triple to MEM/WB. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- Parameters: none (32-bit data/address; RV32I opcodes LOAD=7'b0000011, STORE=7'b0100011)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  register-write enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_op  in  7  opcode from EX/MEM (NOP code when bubbled)
- mem_funct3  in  3  funct3 from EX/MEM
- mem_mem_addr  in  32  effective byte address
- mem_reg  in  32  store data (rs2)
- ram_din  in  8  RAM read byte, valid the cycle after its address
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  RAM write strobe (1 = write ram_dout at ram_addr this cycle)
- ram_dout  out  8  RAM write byte
- wb_wd  out  5  destination register to MEM/WB
- wb_wreg  out  1  register-write enable to MEM/WB
- wb_wdata  out  32  write-back data to MEM/WB
- stallreq_mem  out  1  stall request to the pipeline controller (freezes stall[3:0])

## Operation
- States: IDLE, LOAD, STORE, DONE. A 3-bit byte counter cnt and a 32-bit load buffer are registered. The access size N and signedness are latched on entry.
- Size from funct3: 000/100 → N=1; 001/101 → N=2; 010 → N=4. Loads with funct3 000/001 sign-extend from bit 7/15; 100/101 zero-extend.
- Unsupported funct3 (load 011/110/111, store 011–111): no RAM access, no stall, wb_wreg=0. The instruction completes in IDLE.
- IDLE, op not LOAD/STORE: wb_* = mem_wd/mem_wreg/mem_wdata; stallreq=0; ram_wr=0; ram_addr=0.
- IDLE, op LOAD: stallreq=1, ram_addr=mem_mem_addr. Next state LOAD with cnt=1.
- LOAD, cycle k (k=1..N): if k<N, ram_addr=addr+k. Capture ram_din into buffer byte k-1 (little-endian). After capturing byte N-1, go to DONE. stallreq=1 throughout.
- IDLE, op STORE: stallreq=1, ram_wr=1, ram_addr=addr, ram_dout=mem_reg[7:0]. Next state STORE with cnt=1 if N>1, otherwise DONE.
- STORE, cycle k: ram_wr=1, ram_addr=addr+k, ram_dout=mem_reg[8k+7:8k]. Go to DONE after byte N-1.
- DONE: stallreq=0.
  - Load: wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata = extended buffer.
  - Store: wb_wreg=0.
  - Next state is IDLE. The pipeline advances EX/MEM at the end of this cycle.
- Address increments wrap modulo 2^32. There is no alignment requirement; misaligned accesses are byte-serial like aligned ones.
- ram_wr is never asserted in IDLE with a non-store op, in LOAD, or in DONE.

## Timing
- Non-memory op: 0 cycles, no stall.
- Store: stallreq high for N cycles, completion in cycle N.
  - SB: 1 stall cycle.
  - SW: 4 stall cycles, with writes in cycles 0–3.
- Load: stallreq high for N+1 cycles, data on wb_wdata in cycle N+1.
  - LB: 2 stall cycles.
  - LW: 5 stall cycles.
- EX/MEM inputs are held stable by the stall for the whole access; the block uses them directly, with no re-latching beyond N/sign.
- Back-to-back memory ops: DONE is always followed by IDLE, which starts the next access in the very next cycle.
- Reset: while rst=1, every output is 0 (wb_wd, wb_wreg, wb_wdata, stallreq_mem, ram_addr, ram_wr, ram_dout). State returns to IDLE and cnt and the buffer clear on the next edge.
- Reset mid-access aborts immediately. No further write strobes occur and no partial load data is delivered.

## Test plan
- ALU pass-through: op=0110011, wd=5, wreg=1, wdata=0x1234 → wb_* echo in the same cycle, stallreq=0, ram_wr=0.
- SW to 0x100, mem_reg=0xDEADBEEF:
  - Writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 in cycles 0–3.
  - stallreq high for 4 cycles; cycle 4 shows wb_wreg=0.
- LB at 0x200 holding 0x80 → wb_wdata=0xFFFFFF80 in cycle 2. LBU of the same byte → 0x00000080.
- LW at 0x1FE (misaligned), RAM bytes 11,22,33,44 → reads 0x1FE..0x201, wb_wdata=0x44332211 at cycle 5, stallreq high in cycles 0–4.
- SH at 0xFFFFFFFF, data 0xAB12 → 0x12@0xFFFFFFFF, 0xAB@0x00000000 (wrap).
- Reset asserted in cycle 2 of an SW → ram_wr=0 from that cycle, all outputs 0, IDLE afterwards. A following LW from a clean start behaves normally.
